branch_controller: RTL and testbench

//  Flow-control controller between the instruction decoder and the program sequencer. Adds two things:
//  - a subroutine return-address stack (call/ret);
//  - a single hardware loop counter (loop_start/loop_end).

---
 rtl/cpu_pkg.sv | 18 +
 rtl/return_stack.sv | 62 ++++++
 rtl/branch_controller.sv | 144 ++++++++++++++
 tb/tb_branch_controller.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the flow-control slice.
//   - Default widths/depth used by branch_controller and return_stack.
//   - Loop FSM state encoding.
package cpu_pkg;

   localparam int unsigned DEF_ADDR_W      = 8;
   localparam int unsigned DEF_CNT_W       = 8;
   localparam int unsigned DEF_STACK_DEPTH = 4;

   localparam logic LOOP_IDLE   = 1'b0;
   localparam logic LOOP_ACTIVE = 1'b1;

   typedef enum logic {
      LoopIdle   = LOOP_IDLE,
      LoopActive = LOOP_ACTIVE
   } loop_state_e;

endpackage

// File: rtl/return_stack.sv
// Register-array LIFO holding subroutine return addresses.
// Ports:
//   clk, sync_reset_n : clock, synchronous active-low reset (clears depth only)
//   push_i, data_i    : push data_i (ignored when full)
//   pop_i             : pop top entry (ignored when empty)
//   full_o, empty_o   : occupancy flags
//   top_o             : current top entry (undefined contents when empty)
//   depth_o           : number of entries in use
// The caller never issues push and pop in the same cycle; push takes precedence if it does.
module return_stack
   import cpu_pkg::*;
#(
   parameter int unsigned DEPTH = DEF_STACK_DEPTH,
   parameter int unsigned W     = DEF_ADDR_W,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned DW    = PTR_W + 1
) (
   input  logic          clk,
   input  logic          sync_reset_n,
   input  logic          push_i,
   input  logic          pop_i,
   input  logic [W-1:0]  data_i,
   output logic          full_o,
   output logic          empty_o,
   output logic [W-1:0]  top_o,
   output logic [DW-1:0] depth_o
);

   logic [W-1:0]  mem_q [DEPTH];
   logic [DW-1:0] depth_q, depth_d;
   logic [DW-1:0] top_idx;

   always_comb begin
      full_o  = (depth_q == DW'(DEPTH));
      empty_o = (depth_q == '0);
      top_idx = depth_q - 1'b1;
      top_o   = mem_q[top_idx[PTR_W-1:0]];
      depth_o = depth_q;
      depth_d = depth_q;
      if (push_i && !full_o) begin
         depth_d = depth_q + 1'b1;
      end else if (pop_i && !empty_o) begin
         depth_d = depth_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!sync_reset_n) begin
         depth_q <= '0;
      end else begin
         depth_q <= depth_d;
      end
   end

   // Entries need no reset: they are only read below depth_q.
   always_ff @(posedge clk) begin
      if (sync_reset_n && push_i && !full_o) begin
         mem_q[depth_q[PTR_W-1:0]] <= data_i;
      end
   end

endmodule

// File: rtl/branch_controller.sv
// Flow-control controller between decoder and program sequencer.
// Adds a return-address stack (call/ret) and one hardware loop counter.
// Ports:
//   clk, sync_reset_n          : clock, synchronous active-low reset
//   pc                         : current pc from sequencer
//   call_req/ret_req           : decoder CALL target_addr / RET
//   loop_start/loop_end        : decoder LOOP loop_count (body at pc+1) / end-of-body marker
//   jmp, jmp_addr              : combinational jump request to sequencer
//   stack_depth                : return-stack entries in use
//   loop_active/loop_remaining : loop FSM state and iterations left incl. current
//   err_overflow/underflow/multi : sticky error flags
module branch_controller
   import cpu_pkg::*;
#(
   parameter int unsigned ADDR_W      = DEF_ADDR_W,
   parameter int unsigned STACK_DEPTH = DEF_STACK_DEPTH,
   parameter int unsigned CNT_W       = DEF_CNT_W,
   localparam int unsigned DEPTH_W    = $clog2(STACK_DEPTH) + 1
) (
   input  logic               clk,
   input  logic               sync_reset_n,
   input  logic [ADDR_W-1:0]  pc,
   input  logic               call_req,
   input  logic               ret_req,
   input  logic               loop_start,
   input  logic               loop_end,
   input  logic [ADDR_W-1:0]  target_addr,
   input  logic [CNT_W-1:0]   loop_count,
   output logic               jmp,
   output logic [ADDR_W-1:0]  jmp_addr,
   output logic [DEPTH_W-1:0] stack_depth,
   output logic               loop_active,
   output logic [CNT_W-1:0]   loop_remaining,
   output logic               err_overflow,
   output logic               err_underflow,
   output logic               err_multi
);

   // Priority: ret > call > loop_end > loop_start.
   logic do_ret, do_call, do_end, do_start, multi;
   logic [ADDR_W-1:0] pc_inc;

   logic              stk_push, stk_pop, stk_full, stk_empty;
   logic [ADDR_W-1:0] stk_top;

   loop_state_e       state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [CNT_W-1:0]  rem_q, rem_d;
   logic              ovf_q, ovf_d, udf_q, udf_d, multi_q, multi_d;

   always_comb begin
      do_ret   = ret_req;
      do_call  = call_req & ~ret_req;
      do_end   = loop_end & ~ret_req & ~call_req;
      do_start = loop_start & ~loop_end & ~ret_req & ~call_req;
      multi    = ($countones({call_req, ret_req, loop_start, loop_end}) > 1);
      pc_inc   = pc + 1'b1;
      stk_push = sync_reset_n & do_call & ~stk_full;
      stk_pop  = sync_reset_n & do_ret & ~stk_empty;
   end

   return_stack #(
      .DEPTH (STACK_DEPTH),
      .W     (ADDR_W)
   ) u_return_stack (
      .clk          (clk),
      .sync_reset_n (sync_reset_n),
      .push_i       (stk_push),
      .pop_i        (stk_pop),
      .data_i       (pc_inc),
      .full_o       (stk_full),
      .empty_o      (stk_empty),
      .top_o        (stk_top),
      .depth_o      (stack_depth)
   );

   // Jump mux: combinational, forced low while in reset.
   always_comb begin
      jmp      = 1'b0;
      jmp_addr = '0;
      if (sync_reset_n) begin
         if (do_ret && !stk_empty) begin
            jmp      = 1'b1;
            jmp_addr = stk_top;
         end else if (do_call && !stk_full) begin
            jmp      = 1'b1;
            jmp_addr = target_addr;
         end else if (do_end && state_q == LoopActive && rem_q > CNT_W'(1)) begin
            jmp      = 1'b1;
            jmp_addr = base_q;
         end
      end
   end

   // Loop FSM/counter and sticky errors next-state.
   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      rem_d   = rem_q;
      ovf_d   = ovf_q | (do_call & stk_full);
      udf_d   = udf_q | (do_ret & stk_empty);
      multi_d = multi_q | multi;
      if (do_start) begin
         // Restart from either state; a zero count still runs the body once.
         state_d = LoopActive;
         base_d  = pc_inc;
         rem_d   = (loop_count == '0) ? CNT_W'(1) : loop_count;
      end else if (do_end && state_q == LoopActive) begin
         if (rem_q > CNT_W'(1)) begin
            rem_d = rem_q - 1'b1;
         end else begin
            rem_d   = '0;
            state_d = LoopIdle;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!sync_reset_n) begin
         state_q <= LoopIdle;
         base_q  <= '0;
         rem_q   <= '0;
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
         multi_q <= 1'b0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         rem_q   <= rem_d;
         ovf_q   <= ovf_d;
         udf_q   <= udf_d;
         multi_q <= multi_d;
      end
   end

   always_comb begin
      loop_active    = (state_q == LoopActive);
      loop_remaining = rem_q;
      err_overflow   = ovf_q;
      err_underflow  = udf_q;
      err_multi      = multi_q;
   end

endmodule

// File: tb/tb_branch_controller.sv
module tb_branch_controller;

   logic       clk = 1'b0;
   logic       sync_reset_n;
   logic [7:0] pc, target_addr, loop_count;
   logic       call_req, ret_req, loop_start, loop_end;
   logic       jmp;
   logic [7:0] jmp_addr;
   logic [2:0] stack_depth;
   logic       loop_active;
   logic [7:0] loop_remaining;
   logic       err_overflow, err_underflow, err_multi;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   branch_controller dut (
      .clk            (clk),
      .sync_reset_n   (sync_reset_n),
      .pc             (pc),
      .call_req       (call_req),
      .ret_req        (ret_req),
      .loop_start     (loop_start),
      .loop_end       (loop_end),
      .target_addr    (target_addr),
      .loop_count     (loop_count),
      .jmp            (jmp),
      .jmp_addr       (jmp_addr),
      .stack_depth    (stack_depth),
      .loop_active    (loop_active),
      .loop_remaining (loop_remaining),
      .err_overflow   (err_overflow),
      .err_underflow  (err_underflow),
      .err_multi      (err_multi)
   );

   // Advance past the next rising edge; inputs change and outputs are sampled 1ns later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      call_req = 0; ret_req = 0; loop_start = 0; loop_end = 0;
      pc = 8'h00; target_addr = 8'h00; loop_count = 8'h00;
   endtask

   task automatic apply_reset();
      idle_inputs();
      sync_reset_n = 0;
      tick();
      sync_reset_n = 1;
      #1;
   endtask

   task automatic test_reset();
      idle_inputs();
      sync_reset_n = 0;
      call_req = 1; pc = 8'h10; target_addr = 8'h40;
      #1;
      n_tests++;
      if (jmp !== 1'b0 || jmp_addr !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_jmp: jmp=%b addr=%h, want jmp=0 addr=00", jmp, jmp_addr);
      end
      tick(); tick();
      idle_inputs();
      sync_reset_n = 1;
      #1;
      n_tests++;
      if (stack_depth !== 3'd0 || loop_active !== 1'b0 || loop_remaining !== 8'h00 ||
          {err_overflow, err_underflow, err_multi} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_state: depth=%0d act=%b rem=%h err=%b%b%b, want 0 0 00 000",
                  stack_depth, loop_active, loop_remaining, err_overflow, err_underflow,
                  err_multi);
      end
   endtask

   task automatic test_call_ret();
      apply_reset();
      pc = 8'h10; target_addr = 8'h40; call_req = 1;
      #1;
      n_tests++;
      if (jmp !== 1'b1 || jmp_addr !== 8'h40) begin
         n_fail++;
         $display("FAIL call_jmp: jmp=%b addr=%h, want jmp=1 addr=40", jmp, jmp_addr);
      end
      tick();
      n_tests++;
      if (stack_depth !== 3'd1) begin
         n_fail++;
         $display("FAIL call_depth: depth=%0d, want 1", stack_depth);
      end
      call_req = 0; ret_req = 1; pc = 8'h45;
      #1;
      n_tests++;
      if (jmp !== 1'b1 || jmp_addr !== 8'h11) begin
         n_fail++;
         $display("FAIL ret_jmp: jmp=%b addr=%h, want jmp=1 addr=11", jmp, jmp_addr);
      end
      tick();
      ret_req = 0;
      n_tests++;
      if (stack_depth !== 3'd0 || {err_overflow, err_underflow, err_multi} !== 3'b000) begin
         n_fail++;
         $display("FAIL ret_depth: depth=%0d err=%b%b%b, want 0 000", stack_depth,
                  err_overflow, err_underflow, err_multi);
      end
   endtask

   task automatic test_overflow();
      logic [7:0] exp;
      apply_reset();
      for (int i = 0; i < 4; i++) begin
         call_req = 1; pc = 8'h30 + 8'(i); target_addr = 8'h80 + 8'(i);
         exp = 8'h80 + 8'(i);
         #1;
         n_tests++;
         if (jmp !== 1'b1 || jmp_addr !== exp) begin
            n_fail++;
            $display("FAIL nest_call%0d: jmp=%b addr=%h, want jmp=1 addr=%h", i, jmp,
                     jmp_addr, exp);
         end
         tick();
      end
      pc = 8'h90; target_addr = 8'hA0;
      #1;
      n_tests++;
      if (jmp !== 1'b0 || jmp_addr !== 8'h00) begin
         n_fail++;
         $display("FAIL ovf_jmp: jmp=%b addr=%h, want jmp=0 addr=00", jmp, jmp_addr);
      end
      tick();
      call_req = 0;
      n_tests++;
      if (err_overflow !== 1'b1 || stack_depth !== 3'd4 || err_multi !== 1'b0) begin
         n_fail++;
         $display("FAIL ovf_flag: ovf=%b depth=%0d multi=%b, want 1 4 0", err_overflow,
                  stack_depth, err_multi);
      end
      for (int i = 0; i < 4; i++) begin
         ret_req = 1;
         exp = 8'h34 - 8'(i);
         #1;
         n_tests++;
         if (jmp !== 1'b1 || jmp_addr !== exp) begin
            n_fail++;
            $display("FAIL lifo_ret%0d: jmp=%b addr=%h, want jmp=1 addr=%h", i, jmp,
                     jmp_addr, exp);
         end
         tick();
      end
      ret_req = 0;
      n_tests++;
      if (stack_depth !== 3'd0 || err_underflow !== 1'b0) begin
         n_fail++;
         $display("FAIL lifo_empty: depth=%0d udf=%b, want 0 0", stack_depth, err_underflow);
      end
   endtask

   task automatic test_loop();
      apply_reset();
      pc = 8'h20; loop_count = 8'd3; loop_start = 1;
      #1;
      n_tests++;
      if (jmp !== 1'b0) begin
         n_fail++;
         $display("FAIL loop_start_jmp: jmp=%b, want 0", jmp);
      end
      tick();
      loop_start = 0;
      n_tests++;
      if (loop_active !== 1'b1 || loop_remaining !== 8'd3) begin
         n_fail++;
         $display("FAIL loop_load: act=%b rem=%0d, want 1 3", loop_active, loop_remaining);
      end
      pc = 8'h25; loop_end = 1;
      for (int i = 0; i < 2; i++) begin
         #1;
         n_tests++;
         if (jmp !== 1'b1 || jmp_addr !== 8'h21) begin
            n_fail++;
            $display("FAIL loop_back%0d: jmp=%b addr=%h, want jmp=1 addr=21", i, jmp,
                     jmp_addr);
         end
         tick();
      end
      #1;
      n_tests++;
      if (jmp !== 1'b0 || jmp_addr !== 8'h00 || loop_remaining !== 8'd1) begin
         n_fail++;
         $display("FAIL loop_fall: jmp=%b addr=%h rem=%0d, want 0 00 1", jmp, jmp_addr,
                  loop_remaining);
      end
      tick();
      n_tests++;
      if (loop_active !== 1'b0 || loop_remaining !== 8'd0) begin
         n_fail++;
         $display("FAIL loop_done: act=%b rem=%0d, want 0 0", loop_active, loop_remaining);
      end
      // loop_end still high while IDLE: must be ignored with no error.
      n_tests++;
      if (jmp !== 1'b0 || err_multi !== 1'b0 || err_underflow !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_end: jmp=%b multi=%b udf=%b, want 0 0 0", jmp, err_multi,
                  err_underflow);
      end
      loop_end = 0;
      pc = 8'h20; loop_count = 8'd0; loop_start = 1;
      tick();
      loop_start = 0;
      n_tests++;
      if (loop_active !== 1'b1 || loop_remaining !== 8'd1) begin
         n_fail++;
         $display("FAIL loop_zero_load: act=%b rem=%0d, want 1 1", loop_active,
                  loop_remaining);
      end
      pc = 8'h25; loop_end = 1;
      #1;
      n_tests++;
      if (jmp !== 1'b0) begin
         n_fail++;
         $display("FAIL loop_zero_end: jmp=%b, want 0", jmp);
      end
      tick();
      loop_end = 0;
      n_tests++;
      if (loop_active !== 1'b0) begin
         n_fail++;
         $display("FAIL loop_zero_idle: act=%b, want 0", loop_active);
      end
   endtask

   task automatic test_underflow_priority();
      apply_reset();
      ret_req = 1; pc = 8'h33;
      #1;
      n_tests++;
      if (jmp !== 1'b0 || jmp_addr !== 8'h00) begin
         n_fail++;
         $display("FAIL udf_jmp: jmp=%b addr=%h, want jmp=0 addr=00", jmp, jmp_addr);
      end
      tick();
      ret_req = 0;
      n_tests++;
      if (err_underflow !== 1'b1 || err_multi !== 1'b0 || stack_depth !== 3'd0) begin
         n_fail++;
         $display("FAIL udf_flag: udf=%b multi=%b depth=%0d, want 1 0 0", err_underflow,
                  err_multi, stack_depth);
      end
      call_req = 1; pc = 8'h50; target_addr = 8'h60;
      tick();
      pc = 8'h70; target_addr = 8'h90; ret_req = 1;
      #1;
      n_tests++;
      if (jmp !== 1'b1 || jmp_addr !== 8'h51) begin
         n_fail++;
         $display("FAIL prio_ret_wins: jmp=%b addr=%h, want jmp=1 addr=51", jmp, jmp_addr);
      end
      tick();
      call_req = 0; ret_req = 0;
      n_tests++;
      if (stack_depth !== 3'd0 || err_multi !== 1'b1 || err_overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL prio_state: depth=%0d multi=%b ovf=%b, want 0 1 0", stack_depth,
                  err_multi, err_overflow);
      end
   endtask

   task automatic test_reset_midloop();
      apply_reset();
      pc = 8'h20; loop_count = 8'd3; loop_start = 1;
      tick();
      loop_start = 0; pc = 8'h25; loop_end = 1;
      tick();
      loop_end = 0;
      n_tests++;
      if (loop_remaining !== 8'd2) begin
         n_fail++;
         $display("FAIL midloop_rem: rem=%0d, want 2", loop_remaining);
      end
      sync_reset_n = 0;
      tick();
      sync_reset_n = 1;
      #1;
      n_tests++;
      if (loop_active !== 1'b0 || loop_remaining !== 8'd0) begin
         n_fail++;
         $display("FAIL midloop_reset: act=%b rem=%0d, want 0 0", loop_active,
                  loop_remaining);
      end
      loop_end = 1;
      #1;
      n_tests++;
      if (jmp !== 1'b0) begin
         n_fail++;
         $display("FAIL midloop_end: jmp=%b, want 0", jmp);
      end
      loop_end = 0; pc = 8'hFF; target_addr = 8'h10; call_req = 1;
      #1;
      n_tests++;
      if (jmp !== 1'b1 || jmp_addr !== 8'h10) begin
         n_fail++;
         $display("FAIL wrap_call: jmp=%b addr=%h, want jmp=1 addr=10", jmp, jmp_addr);
      end
      tick();
      call_req = 0; ret_req = 1; pc = 8'h12;
      #1;
      n_tests++;
      if (jmp !== 1'b1 || jmp_addr !== 8'h00) begin
         n_fail++;
         $display("FAIL wrap_ret: jmp=%b addr=%h, want jmp=1 addr=00", jmp, jmp_addr);
      end
      tick();
      ret_req = 0;
      n_tests++;
      if (stack_depth !== 3'd0) begin
         n_fail++;
         $display("FAIL wrap_depth: depth=%0d, want 0", stack_depth);
      end
   endtask

   initial begin
      idle_inputs();
      sync_reset_n = 0;
      test_reset();
      test_call_ret();
      test_overflow();
      test_loop();
      test_underflow_priority();
      test_reset_midloop();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
